// File: rtl/forward_stall_unit_if.sv
// Bundles the forwarding / hazard / mult-div signals of forward_stall_unit.
//   master : pipeline side, drives the i_* signals and observes the o_* signals
//   slave  : forward_stall_unit side
// Inputs : per-source RegWrite/Rd, ID/EX Rs/Rt/MemRead/Rd, IF/ID Rs/Rt/uses-Rt,
//          mult/div start, stall-counter clear
// Outputs: ALU operand mux selects, stall, bubble, busy, saturating stall counter
interface forward_stall_unit_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned N_SRC      = 2,
  parameter int unsigned CNT_W      = 16
);
  localparam int unsigned SEL_W = $clog2(N_SRC + 1);

  logic [N_SRC-1:0]            i_src_regwrite;
  logic [N_SRC*REG_ADDR_W-1:0] i_src_rd;
  logic [REG_ADDR_W-1:0]       i_ex_rs;
  logic [REG_ADDR_W-1:0]       i_ex_rt;
  logic                        i_ex_memread;
  logic [REG_ADDR_W-1:0]       i_ex_rd;
  logic [REG_ADDR_W-1:0]       i_id_rs;
  logic [REG_ADDR_W-1:0]       i_id_rt;
  logic                        i_id_uses_rt;
  logic                        i_muldiv_start;
  logic                        i_clr_count;
  logic [SEL_W-1:0]            o_mux_a_sel;
  logic [SEL_W-1:0]            o_mux_b_sel;
  logic                        o_stall;
  logic                        o_bubble;
  logic                        o_busy;
  logic [CNT_W-1:0]            o_stall_count;

  modport master (
    output i_src_regwrite, i_src_rd, i_ex_rs, i_ex_rt, i_ex_memread, i_ex_rd,
           i_id_rs, i_id_rt, i_id_uses_rt, i_muldiv_start, i_clr_count,
    input  o_mux_a_sel, o_mux_b_sel, o_stall, o_bubble, o_busy, o_stall_count
  );

  modport slave (
    input  i_src_regwrite, i_src_rd, i_ex_rs, i_ex_rt, i_ex_memread, i_ex_rd,
           i_id_rs, i_id_rt, i_id_uses_rt, i_muldiv_start, i_clr_count,
    output o_mux_a_sel, o_mux_b_sel, o_stall, o_bubble, o_busy, o_stall_count
  );
endinterface

// File: rtl/forward_stall_unit.sv
// EX-stage forwarding unit with load-use hazard detection and a mult/div stall FSM.
//   i_clk     : clock, rising edge
//   i_reset_n : asynchronous active-low reset
//   bus       : forward_stall_unit_if.slave
//     o_mux_a_sel / o_mux_b_sel : 0 = register file, k+1 = forwarding source k (0 youngest)
//     o_stall   : freeze PC, IF/ID, ID/EX (load-use bubble cycle or mult/div busy)
//     o_bubble  : insert NOP into ID/EX, load-use only
//     o_busy    : registered, high while a mult/div op is in flight
//     o_stall_count : saturating count of stall cycles, synchronous clear
// Interface parameters must match the module parameters of the same name.
module forward_stall_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned N_SRC      = 2,
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 16
) (
  input logic               i_clk,
  input logic               i_reset_n,
  forward_stall_unit_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(N_SRC + 1);
  // The FSM counts down from LAT-1 to 0, giving exactly MULDIV_LAT busy cycles.
  localparam logic [7:0]  LatM1 = 8'(MULDIV_LAT - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             busy_q;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic [SEL_W-1:0]      sel_a, sel_b;
  logic [REG_ADDR_W-1:0] rd_k;
  logic                  load_use_hit;
  logic                  stall, bubble;

  // Forwarding: walk from oldest to youngest so the youngest match overwrites.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    rd_k  = '0;
    for (int k = int'(N_SRC) - 1; k >= 0; k--) begin
      rd_k = bus.i_src_rd[k*REG_ADDR_W +: REG_ADDR_W];
      if (bus.i_src_regwrite[k] && (rd_k != '0)) begin
        if (rd_k == bus.i_ex_rs) sel_a = SEL_W'(k + 1);
        if (rd_k == bus.i_ex_rt) sel_b = SEL_W'(k + 1);
      end
    end
  end

  assign load_use_hit = bus.i_ex_memread && (bus.i_ex_rd != '0) &&
                        ((bus.i_ex_rd == bus.i_id_rs) ||
                         (bus.i_id_uses_rt && (bus.i_ex_rd == bus.i_id_rt)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_use_hit) begin
          stall  = 1'b1;
          bubble = 1'b1;
        end
        // A simultaneous load-use hit still gets its bubble this cycle.
        if (bus.i_muldiv_start) begin
          state_d = StBusy;
          cnt_d   = LatM1;
        end
      end
      StBusy: begin
        stall = 1'b1;
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (bus.i_clr_count) begin
      stall_count_d = '0;
    end else if (stall && !(&stall_count_q)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= StIdle;
      cnt_q         <= 8'd0;
      busy_q        <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      busy_q        <= (state_d == StBusy);
      stall_count_q <= stall_count_d;
    end
  end

  // Combinational outputs are held low while reset is asserted.
  assign bus.o_mux_a_sel   = i_reset_n ? sel_a : '0;
  assign bus.o_mux_b_sel   = i_reset_n ? sel_b : '0;
  assign bus.o_stall       = i_reset_n & stall;
  assign bus.o_bubble      = i_reset_n & bubble;
  assign bus.o_busy        = busy_q;
  assign bus.o_stall_count = stall_count_q;
endmodule

// File: tb/tb_forward_stall_unit.sv
// Bench for forward_stall_unit: two instances (default parameters, and N_SRC=3 /
// REG_ADDR_W=6 / CNT_W=2 / MULDIV_LAT=3) checked every cycle against a model that
// tracks "stall cycles remaining" and a plain saturating stall count.
module tb_forward_stall_unit;
  typedef struct {
    int regw;
    int rd[3];
    int ex_rs, ex_rt, memread, ex_rd, id_rs, id_rt, uses_rt, start, clr;
  } stim_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  stim_t st[2];
  int    bl[2];      // model: stall cycles still owed to a mult/div op
  int    cm[2];      // model: stall counter
  int    es[2];      // model: expected o_stall in the current cycle
  int    n_chk = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  forward_stall_unit_if #(.REG_ADDR_W(5), .N_SRC(2), .CNT_W(16)) ifa ();
  forward_stall_unit_if #(.REG_ADDR_W(6), .N_SRC(3), .CNT_W(2))  ifb ();

  forward_stall_unit #(.REG_ADDR_W(5), .N_SRC(2), .MULDIV_LAT(4), .CNT_W(16)) dut_a (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (ifa.slave)
  );

  forward_stall_unit #(.REG_ADDR_W(6), .N_SRC(3), .MULDIV_LAT(3), .CNT_W(2)) dut_b (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (ifb.slave)
  );

  assign ifa.i_src_regwrite = st[0].regw[1:0];
  assign ifa.i_src_rd       = {st[0].rd[1][4:0], st[0].rd[0][4:0]};
  assign ifa.i_ex_rs        = st[0].ex_rs[4:0];
  assign ifa.i_ex_rt        = st[0].ex_rt[4:0];
  assign ifa.i_ex_memread   = st[0].memread[0];
  assign ifa.i_ex_rd        = st[0].ex_rd[4:0];
  assign ifa.i_id_rs        = st[0].id_rs[4:0];
  assign ifa.i_id_rt        = st[0].id_rt[4:0];
  assign ifa.i_id_uses_rt   = st[0].uses_rt[0];
  assign ifa.i_muldiv_start = st[0].start[0];
  assign ifa.i_clr_count    = st[0].clr[0];

  assign ifb.i_src_regwrite = st[1].regw[2:0];
  assign ifb.i_src_rd       = {st[1].rd[2][5:0], st[1].rd[1][5:0], st[1].rd[0][5:0]};
  assign ifb.i_ex_rs        = st[1].ex_rs[5:0];
  assign ifb.i_ex_rt        = st[1].ex_rt[5:0];
  assign ifb.i_ex_memread   = st[1].memread[0];
  assign ifb.i_ex_rd        = st[1].ex_rd[5:0];
  assign ifb.i_id_rs        = st[1].id_rs[5:0];
  assign ifb.i_id_rt        = st[1].id_rt[5:0];
  assign ifb.i_id_uses_rt   = st[1].uses_rt[0];
  assign ifb.i_muldiv_start = st[1].start[0];
  assign ifb.i_clr_count    = st[1].clr[0];

  function automatic int nsrc(int n);
    return (n == 0) ? 2 : 3;
  endfunction

  function automatic int lat(int n);
    return (n == 0) ? 4 : 3;
  endfunction

  function automatic int cmax(int n);
    return (n == 0) ? 65535 : 3;
  endfunction

  // Youngest (lowest index) writing source with a matching non-zero Rd.
  function automatic int fwd_sel(int n, int addr);
    for (int k = 0; k < nsrc(n); k++) begin
      if (st[n].regw[k] && st[n].rd[k] != 0 && st[n].rd[k] == addr) return k + 1;
    end
    return 0;
  endfunction

  function automatic bit lu_hit(int n);
    return st[n].memread != 0 && st[n].ex_rd != 0 &&
           (st[n].ex_rd == st[n].id_rs || (st[n].uses_rt != 0 && st[n].ex_rd == st[n].id_rt));
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] o_a, o_b, o_s, o_bu, o_by, o_c;
    int  ea, eb;
    bit  hit;
    string p;
    #1;
    for (int n = 0; n < 2; n++) begin
      p = (n == 0) ? "A." : "B.";
      if (n == 0) begin
        o_a = 32'(ifa.o_mux_a_sel); o_b = 32'(ifa.o_mux_b_sel); o_s = 32'(ifa.o_stall);
        o_bu = 32'(ifa.o_bubble); o_by = 32'(ifa.o_busy); o_c = 32'(ifa.o_stall_count);
      end else begin
        o_a = 32'(ifb.o_mux_a_sel); o_b = 32'(ifb.o_mux_b_sel); o_s = 32'(ifb.o_stall);
        o_bu = 32'(ifb.o_bubble); o_by = 32'(ifb.o_busy); o_c = 32'(ifb.o_stall_count);
      end
      ea    = rst_n ? fwd_sel(n, st[n].ex_rs) : 0;
      eb    = rst_n ? fwd_sel(n, st[n].ex_rt) : 0;
      hit   = rst_n && bl[n] == 0 && lu_hit(n);
      es[n] = (rst_n && (bl[n] > 0 || hit)) ? 1 : 0;
      chk({p, "sel_a"}, o_a, 32'(ea));
      chk({p, "sel_b"}, o_b, 32'(eb));
      chk({p, "stall"}, o_s, 32'(es[n]));
      chk({p, "bubble"}, o_bu, 32'(hit));
      chk({p, "busy"}, o_by, 32'(bl[n] > 0));
      chk({p, "count"}, o_c, 32'(cm[n]));
    end
  endtask

  task automatic cycle(int reps = 1);
    for (int r = 0; r < reps; r++) begin
      check_all();
      @(posedge clk);
      if (rst_n) begin
        for (int n = 0; n < 2; n++) begin
          if (st[n].clr != 0) cm[n] = 0;
          else if (es[n] != 0 && cm[n] < cmax(n)) cm[n] = cm[n] + 1;
          if (bl[n] > 0) bl[n] = bl[n] - 1;
          else if (st[n].start != 0) bl[n] = lat(n);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic set_reset(logic v);
    rst_n = v;
    if (!v) begin
      for (int n = 0; n < 2; n++) begin
        bl[n] = 0;
        cm[n] = 0;
      end
    end
  endtask

  task automatic clear_stim();
    for (int n = 0; n < 2; n++) begin
      st[n].regw = 0;
      for (int k = 0; k < 3; k++) st[n].rd[k] = 0;
      st[n].ex_rs = 0; st[n].ex_rt = 0; st[n].memread = 0; st[n].ex_rd = 0;
      st[n].id_rs = 0; st[n].id_rt = 0; st[n].uses_rt = 0; st[n].start = 0; st[n].clr = 0;
    end
  endtask

  initial begin
    clear_stim();
    set_reset(1'b0);
    @(negedge clk);
    // Reset state, with inputs that would otherwise forward/stall.
    st[0].regw = 1; st[0].rd[0] = 5; st[0].ex_rs = 5;
    st[0].memread = 1; st[0].ex_rd = 5; st[0].id_rs = 5;
    cycle(2);
    clear_stim();
    set_reset(1'b1);
    cycle();

    // Forwarding from source 0, then source 1.
    st[0].regw = 1; st[0].rd[0] = 5; st[0].ex_rs = 5; cycle();
    st[0].regw = 0; cycle();
    st[0].rd[1] = 4; st[0].ex_rt = 4; st[0].regw = 2; cycle();
    st[0].regw = 0; cycle();
    // Youngest wins; Rd=0 never forwards.
    st[0].rd[0] = 5; st[0].rd[1] = 5; st[0].regw = 3; st[0].ex_rs = 5; cycle();
    st[0].rd[0] = 0; st[0].ex_rs = 0; st[0].regw = 1; cycle();
    clear_stim();

    // Load-use hit on Rs, Rt ignored unless used, ex_rd=0 never stalls.
    st[0].memread = 1; st[0].ex_rd = 7; st[0].id_rs = 7; cycle();
    st[0].id_rs = 0; st[0].id_rt = 7; st[0].uses_rt = 0; cycle();
    st[0].uses_rt = 1; cycle();
    st[0].ex_rd = 0; cycle();
    clear_stim();
    st[0].clr = 1; cycle();
    st[0].clr = 0;

    // Mult/div: four busy cycles, start pulses inside BUSY ignored, load-use masked.
    st[0].start = 1; cycle();
    st[0].start = 0; cycle(2);
    st[0].start = 1; st[0].memread = 1; st[0].ex_rd = 3; st[0].id_rs = 3; cycle();
    clear_stim(); cycle(4);

    // Simultaneous hit and start: bubble then BUSY, count 5.
    st[0].clr = 1; cycle();
    st[0].clr = 0; st[0].memread = 1; st[0].ex_rd = 7; st[0].id_rs = 7; st[0].start = 1;
    cycle();
    clear_stim(); cycle(5);
    // Clear during a stall cycle beats the increment.
    st[0].start = 1; cycle();
    st[0].start = 0; cycle();
    st[0].clr = 1; cycle();
    st[0].clr = 0; cycle(4);

    // Wide instance: source 2 with a 6-bit Rd, and counter saturation at 3.
    st[1].regw = 4; st[1].rd[2] = 33; st[1].ex_rs = 33; st[1].ex_rt = 33; cycle();
    clear_stim();
    st[1].start = 1; cycle();
    st[1].start = 0; cycle(4);
    st[1].start = 1; cycle();
    st[1].start = 0; cycle(4);

    // Reset mid-BUSY aborts the op at once; nothing resumes after release.
    st[0].start = 1; cycle();
    st[0].start = 0; cycle();
    set_reset(1'b0); cycle(2);
    set_reset(1'b1); cycle(4);

    // Randomized traffic on both instances.
    for (int i = 0; i < 500; i++) begin
      for (int n = 0; n < 2; n++) begin
        st[n].regw = int'($urandom_range(0, 7));
        for (int k = 0; k < 3; k++) st[n].rd[k] = int'($urandom_range(0, 7));
        st[n].ex_rs   = int'($urandom_range(0, 7));
        st[n].ex_rt   = int'($urandom_range(0, 7));
        st[n].memread = int'($urandom_range(0, 1));
        st[n].ex_rd   = int'($urandom_range(0, 7));
        st[n].id_rs   = int'($urandom_range(0, 7));
        st[n].id_rt   = int'($urandom_range(0, 7));
        st[n].uses_rt = int'($urandom_range(0, 1));
        st[n].start   = ($urandom_range(0, 7) == 0) ? 1 : 0;
        st[n].clr     = ($urandom_range(0, 39) == 0) ? 1 : 0;
      end
      if ($urandom_range(0, 79) == 0) set_reset(1'b0);
      else if (!rst_n) set_reset(1'b1);
      cycle();
    end
    set_reset(1'b1);
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
